ds_despreader: RTL and testbench
================================

# ds_despreader

Direct-sequence despreader for the spread-spectrum signal chain. It consumes a stream of signed 16-bit baseband samples (AXI-Stream style, valid-only, no backpressure), multiplies each sample by the locally generated ±1 PN chip, and integrates over one full PN period. At the end of each period it emits one hard-decision data bit plus the raw correlation value. It is the receive-side counterpart of the generator's spreading/DDS path and sits directly downstream of the sample source clocked on `aclk`.

## Interface

Parameters:
- `DATA_W`, 16: input sample width, two's complement.
- `SPC`, 4: samples per chip, ≥1.
- `CHIPS`, 31: chips per symbol, equal to one PN period.
- `ACC_W`, DATA_W+clog2(SPC*CHIPS)+1: correlation accumulator width, derived, not overridden.

Ports:
- `aclk` in 1: single clock for the whole block.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: one-cycle pulse that (re)aligns the PN and begins despreading.
- `s_axis_data_tvalid` in 1: sample valid.
- `s_axis_data_tdata` in DATA_W: signed sample.
- `m_axis_bit_tvalid` out 1: one-cycle pulse per decided symbol.
- `m_axis_bit_tdata` out 1: decided bit.
- `corr_tdata` out ACC_W: signed correlation for the same symbol, valid with `m_axis_bit_tvalid`.
- `busy` out 1: high in RUN state.

## Operation

- States are IDLE and RUN. Reset enters IDLE. `start` moves any state to RUN. RUN does not leave except on `start` (restart) or `rst`.
- On `start`: load the LFSR seed and clear the sample counter, chip counter and accumulator. A sample presented in the same cycle as `start` is discarded.
- PN: Fibonacci LFSR, x^5+x^3+1, seed 5'b00001. The chip is the LFSR output bit. Chip 0 maps to +1 and chip 1 maps to −1. The LFSR reloads the seed at every symbol boundary.
- Per valid sample in RUN: sign-extend to ACC_W, then negate if the chip is 1, then add to the accumulator. Negation happens after extension, so −2^(DATA_W−1) is exact.
- The sample counter runs 0..SPC−1. On SPC−1 it wraps, the LFSR steps, and the chip counter increments.
- Last sample of the symbol (chip CHIPS−1, sample SPC−1):
  - `corr_tdata` ← final sum, including this sample.
  - `m_axis_bit_tdata` ← 1 if the sum is < 0, otherwise 0.
  - `m_axis_bit_tvalid` pulses.
  - The accumulator clears, so the next sample starts a fresh sum.
- Invalid cycles (`tvalid` = 0) leave all state unchanged; gaps of any length are allowed.
- Samples in IDLE are ignored.
- The sink has no `tready`; it must accept every pulse.

## Timing

- Reset values: `m_axis_bit_tvalid` = 0, `m_axis_bit_tdata` = 0, `corr_tdata` = 0, `busy` = 0. The LFSR holds the seed and all counters are 0.
- Latency: `m_axis_bit_tvalid` is high exactly one cycle, in the cycle after the symbol's last valid sample is sampled.
- `corr_tdata` and `m_axis_bit_tdata` hold their values until the next symbol.
- `busy` rises the cycle after `start`.
- `start` mid-symbol: the partial sum is dropped with no output pulse.
- `start` in the same cycle as a last sample: `start` wins, and there is no output.
- `rst` mid-symbol: asynchronous clear to the reset values above, then IDLE.
- Overflow is impossible by construction: |sum| ≤ SPC·CHIPS·2^(DATA_W−1) < 2^(ACC_W−1).

## Structure

- Shared package `ss_pkg` holds:
  - the `clog2` function;
  - LFSR width, tap mask and seed constants (shared with the transmit spreader);
  - the state enum {IDLE, RUN}.
- Sub-module `pn_lfsr` has ports `aclk`, `rst`, `load`, `step`, `chip`. The transmit side reuses it.
- The top level holds the FSM, the counters, the accumulator and the output registers.

## Test plan

All scenarios use default parameters, so one symbol is 124 samples and ACC_W = 24.

1. Constant input +1000 for 124 valid samples after `start`. The PN period has 16 ones and 15 zeros. Expect `corr_tdata` = −4000, bit = 1, and exactly one tvalid pulse.
2. Input = 8192·(1−2·chip), sample-aligned to the PN. Expect `corr_tdata` = 1015808 and bit = 0. Repeat with the sign inverted: expect −1015808 and bit = 1.
3. Full scale, sample = chip ? −32768 : +32767. Expect `corr_tdata` = 4063172, bit = 0, with no wrap.
4. Repeat scenario 2 with tvalid high only every 3rd cycle. Results must be identical, and tvalid must pulse the cycle after the 124th valid sample.
5. Pulse `start` again after 50 samples. Expect no output pulse, then a correct result after 124 further samples. Also check `start` coinciding with the 124th sample: no pulse.
6. Assert `rst` mid-symbol. All outputs go to 0 immediately and `busy` = 0. No tvalid while samples continue without `start`, and samples in IDLE are ignored.

Source files
------------

// File: rtl/ss_pkg.sv
// ss_pkg: shared spread-spectrum constants, PN LFSR definition, despreader FSM states
package ss_pkg;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  localparam int LFSR_W = 5;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 5'b01001;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 5'b00001;
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/pn_lfsr.sv
// pn_lfsr: Fibonacci PN generator x^5+x^3+1; ports aclk, rst (async), load (seed), step (advance), chip (output bit)
module pn_lfsr import ss_pkg::*; (
  input  logic aclk,
  input  logic rst,
  input  logic load,
  input  logic step,
  output logic chip
);
  logic [LFSR_W-1:0] r;
  always_ff @(posedge aclk or posedge rst)
    if (rst) r <= LFSR_SEED;
    else if (load) r <= LFSR_SEED;
    else if (step) r <= {^(r & LFSR_TAPS), r[LFSR_W-1:1]};
  assign chip = r[0];
endmodule

// File: rtl/ds_despreader.sv
// ds_despreader: multiplies samples by the PN chip and integrates per PN period; ports aclk, rst, start, s_axis_data_*, m_axis_bit_*, corr_tdata, busy
module ds_despreader import ss_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int SPC = 4,
  parameter int CHIPS = 31,
  localparam int ACC_W = DATA_W + clog2(SPC * CHIPS) + 1
) (
  input  logic              aclk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_axis_data_tvalid,
  input  logic [DATA_W-1:0] s_axis_data_tdata,
  output logic              m_axis_bit_tvalid,
  output logic              m_axis_bit_tdata,
  output logic [ACC_W-1:0]  corr_tdata,
  output logic              busy
);
  localparam int SC_W = clog2(SPC) > 0 ? clog2(SPC) : 1;
  localparam int CC_W = clog2(CHIPS) > 0 ? clog2(CHIPS) : 1;
  state_t state, next_state;
  logic [SC_W-1:0] spc_cnt;
  logic [CC_W-1:0] chip_cnt;
  logic [ACC_W-1:0] acc, ext, sum;
  logic chip, adv, last_spc, last;
  always_comb begin
    next_state = start ? RUN : state;
    busy = state == RUN;
  end
  // a sample arriving with start is dropped, so start also wins over a symbol end
  assign adv = busy && s_axis_data_tvalid && !start;
  assign last_spc = spc_cnt == SC_W'(SPC - 1);
  assign last = adv && last_spc && chip_cnt == CC_W'(CHIPS - 1);
  // negate after extension so the most negative sample stays exact
  assign ext = {{(ACC_W - DATA_W){s_axis_data_tdata[DATA_W-1]}}, s_axis_data_tdata};
  assign sum = acc + (chip ? -ext : ext);
  pn_lfsr u_pn (
    .aclk (aclk),
    .rst  (rst),
    .load (start || last),
    .step (adv && last_spc),
    .chip (chip)
  );
  always_ff @(posedge aclk or posedge rst)
    if (rst) begin
      state <= IDLE;
      spc_cnt <= '0;
      chip_cnt <= '0;
      acc <= '0;
      m_axis_bit_tvalid <= 1'b0;
      m_axis_bit_tdata <= 1'b0;
      corr_tdata <= '0;
    end else begin
      state <= next_state;
      m_axis_bit_tvalid <= last;
      if (start) begin
        spc_cnt <= '0;
        chip_cnt <= '0;
        acc <= '0;
      end else if (adv) begin
        spc_cnt <= last_spc ? '0 : spc_cnt + 1'b1;
        if (last_spc) chip_cnt <= last ? '0 : chip_cnt + 1'b1;
        acc <= last ? '0 : sum;
        if (last) begin
          corr_tdata <= sum;
          m_axis_bit_tdata <= sum[ACC_W-1];
        end
      end
    end
endmodule

// File: tb/tb_ds_despreader.sv
// tb_ds_despreader: table-driven and randomized checks of ds_despreader against a PN-sequence reference model
module tb_ds_despreader;
  localparam int SPC = 4;
  localparam int CHIPS = 31;
  localparam int NS = SPC * CHIPS;
  logic aclk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic s_axis_data_tvalid = 1'b0;
  logic [15:0] s_axis_data_tdata = '0;
  logic m_axis_bit_tvalid, m_axis_bit_tdata, busy;
  logic [23:0] corr_tdata;
  int errors = 0;
  int checks = 0;
  int pulses = 0;
  int pn[CHIPS];
  typedef struct {
    int mode;
    int gap;
    longint corr;
    logic bitv;
  } vec_t;
  vec_t vecs[5];
  ds_despreader dut (
    .aclk               (aclk),
    .rst                (rst),
    .start              (start),
    .s_axis_data_tvalid (s_axis_data_tvalid),
    .s_axis_data_tdata  (s_axis_data_tdata),
    .m_axis_bit_tvalid  (m_axis_bit_tvalid),
    .m_axis_bit_tdata   (m_axis_bit_tdata),
    .corr_tdata         (corr_tdata),
    .busy               (busy)
  );
  always #5 aclk = ~aclk;
  always @(negedge aclk) if (m_axis_bit_tvalid) pulses++;
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic drive(input logic v, input int d, input logic st);
    @(negedge aclk);
    s_axis_data_tvalid = v;
    s_axis_data_tdata = 16'(d);
    start = st;
    @(posedge aclk);
    #1;
  endtask
  function automatic int gen(input int mode, input int i);
    int c;
    c = pn[i / SPC];
    case (mode)
      0: return 1000;
      1: return c ? -8192 : 8192;
      2: return c ? 8192 : -8192;
      3: return c ? -32768 : 32767;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction
  function automatic longint model(input int s[$]);
    longint acc;
    acc = 0;
    foreach (s[i]) acc += pn[i / SPC] ? -longint'(s[i]) : longint'(s[i]);
    return acc;
  endfunction
  // sends one full symbol; gap<0 means random gaps; returns model sum
  task automatic run_symbol(input int mode, input int gap, input string name, output longint exp);
    int s[$];
    int p0;
    p0 = pulses;
    for (int i = 0; i < NS; i++) begin
      int g;
      g = gap < 0 ? int'($urandom_range(0, 3)) : gap;
      for (int k = 0; k < g; k++) drive(1'b0, int'($urandom_range(0, 65535)), 1'b0);
      s.push_back(gen(mode, i));
      drive(1'b1, s[i], 1'b0);
      if (i == NS - 2) chk({name, " no early pulse"}, pulses - p0, 0);
    end
    exp = model(s);
    chk({name, " tvalid after last"}, m_axis_bit_tvalid, 1);
    chk({name, " corr model"}, longint'($signed(corr_tdata)), exp);
    chk({name, " bit model"}, m_axis_bit_tdata, exp < 0);
    drive(1'b0, 0, 1'b0);
    chk({name, " one pulse"}, pulses - p0, 1);
    chk({name, " corr hold"}, longint'($signed(corr_tdata)), exp);
  endtask
  initial begin
    longint e;
    int p0;
    pn[0] = 1;
    for (int n = 1; n < 5; n++) pn[n] = 0;
    for (int n = 0; n + 5 < CHIPS; n++) pn[n + 5] = pn[n + 3] ^ pn[n];
    vecs[0] = '{0, 0, -4000, 1'b1};
    vecs[1] = '{1, 0, 1015808, 1'b0};
    vecs[2] = '{2, 0, -1015808, 1'b1};
    vecs[3] = '{3, 0, 4063172, 1'b0};
    vecs[4] = '{1, 2, 1015808, 1'b0};
    repeat (3) @(posedge aclk);
    #1;
    chk("reset tvalid", m_axis_bit_tvalid, 0);
    chk("reset bit", m_axis_bit_tdata, 0);
    chk("reset corr", corr_tdata, 0);
    chk("reset busy", busy, 0);
    @(negedge aclk);
    rst = 1'b0;
    drive(1'b1, 1234, 1'b0);
    chk("idle busy", busy, 0);
    drive(1'b1, 777, 1'b1);
    chk("busy after start", busy, 1);
    foreach (vecs[v]) begin
      run_symbol(vecs[v].mode, vecs[v].gap, $sformatf("vec%0d", v), e);
      chk($sformatf("vec%0d corr table", v), longint'($signed(corr_tdata)), vecs[v].corr);
      chk($sformatf("vec%0d bit table", v), m_axis_bit_tdata, vecs[v].bitv);
    end
    for (int r = 0; r < 3; r++) run_symbol(4, -1, $sformatf("rand%0d", r), e);
    p0 = pulses;
    for (int i = 0; i < 50; i++) drive(1'b1, 30000, 1'b0);
    drive(1'b1, 30000, 1'b1);
    drive(1'b0, 0, 1'b0);
    chk("restart no pulse", pulses - p0, 0);
    run_symbol(1, 0, "after restart", e);
    chk("after restart corr", longint'($signed(corr_tdata)), 1015808);
    p0 = pulses;
    for (int i = 0; i < NS - 1; i++) drive(1'b1, gen(0, i), 1'b0);
    drive(1'b1, 1000, 1'b1);
    chk("start on last tvalid", m_axis_bit_tvalid, 0);
    drive(1'b0, 0, 1'b0);
    chk("start on last pulses", pulses - p0, 0);
    chk("start on last corr hold", longint'($signed(corr_tdata)), 1015808);
    run_symbol(2, 0, "after last restart", e);
    chk("after last restart corr", longint'($signed(corr_tdata)), -1015808);
    for (int i = 0; i < 60; i++) drive(1'b1, 5000, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("async rst corr", corr_tdata, 0);
    chk("async rst bit", m_axis_bit_tdata, 0);
    chk("async rst busy", busy, 0);
    @(negedge aclk);
    rst = 1'b0;
    p0 = pulses;
    for (int i = 0; i < NS + 10; i++) drive(1'b1, 4000, 1'b0);
    chk("idle no pulse", pulses - p0, 0);
    chk("idle busy low", busy, 0);
    chk("idle corr zero", corr_tdata, 0);
    drive(1'b0, 0, 1'b1);
    run_symbol(0, 0, "after reset", e);
    chk("after reset corr", longint'($signed(corr_tdata)), -4000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
